key_token_encoder: RTL and testbench

Front-end key stage feeding `MB_INTERFACE`. Synchronises and debounces the 16 raw calculator button lines, resolves SHIFT into the parenthesis keys, encodes each accepted press into a 5-bit key token, and buffers tokens in a small FIFO. Tokens go to the interface logic over a valid/ready handshake. `MB_INTERFACE` consumes tokens instead of raw buttons.

---
 rtl/calc_key_pkg.sv | 58 +++++
 rtl/key_fifo.sv | 83 ++++++++
 rtl/key_token_encoder.sv | 152 +++++++++++++++
 tb/tb_key_token_encoder.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/calc_key_pkg.sv
// Shared key-token definitions for the calculator key front end and MB_INTERFACE.
package calc_key_pkg;

  localparam int unsigned KEY_W = 5;

  localparam logic [KEY_W-1:0] KEY_0    = 5'd0;
  localparam logic [KEY_W-1:0] KEY_1    = 5'd1;
  localparam logic [KEY_W-1:0] KEY_2    = 5'd2;
  localparam logic [KEY_W-1:0] KEY_3    = 5'd3;
  localparam logic [KEY_W-1:0] KEY_4    = 5'd4;
  localparam logic [KEY_W-1:0] KEY_5    = 5'd5;
  localparam logic [KEY_W-1:0] KEY_6    = 5'd6;
  localparam logic [KEY_W-1:0] KEY_7    = 5'd7;
  localparam logic [KEY_W-1:0] KEY_8    = 5'd8;
  localparam logic [KEY_W-1:0] KEY_9    = 5'd9;
  localparam logic [KEY_W-1:0] KEY_DOT  = 5'd10;
  localparam logic [KEY_W-1:0] KEY_EQ   = 5'd11;
  localparam logic [KEY_W-1:0] KEY_ADD  = 5'd12;
  localparam logic [KEY_W-1:0] KEY_SUB  = 5'd13;
  localparam logic [KEY_W-1:0] KEY_MUL  = 5'd14;
  localparam logic [KEY_W-1:0] KEY_DIV  = 5'd15;
  localparam logic [KEY_W-1:0] KEY_LPAR = 5'd16;
  localparam logic [KEY_W-1:0] KEY_RPAR = 5'd17;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PRESS   = 2'd1,
    ST_HELD    = 2'd2,
    ST_RELEASE = 2'd3
  } key_state_e;

  // Key vector layout: [9:0] digit lines, [10] dot, [11] equal, [15:12] operators (+,-,*,/ from MSB).
  function automatic logic [KEY_W-1:0] encode_key(input logic [15:0] pat, input logic sh);
    logic [KEY_W-1:0] code;
    code = KEY_0;
    case (pat)
      16'h0001: code = KEY_0;
      16'h0002: code = KEY_9;
      16'h0004: code = KEY_8;
      16'h0008: code = KEY_7;
      16'h0010: code = KEY_6;
      16'h0020: code = KEY_5;
      16'h0040: code = KEY_4;
      16'h0080: code = KEY_3;
      16'h0100: code = KEY_2;
      16'h0200: code = KEY_1;
      16'h0400: code = KEY_DOT;
      16'h0800: code = KEY_EQ;
      16'h1000: code = KEY_DIV;
      16'h2000: code = KEY_MUL;
      16'h4000: code = sh ? KEY_RPAR : KEY_SUB;
      16'h8000: code = sh ? KEY_LPAR : KEY_ADD;
      default:  code = KEY_0;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/key_fifo.sv
// Small token FIFO; head, full and empty are registered so consumers see clean levels.
module key_fifo #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned KEY_W      = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic [KEY_W-1:0] i_din,
  input  logic             i_pop,
  output logic             o_full,
  output logic             o_empty,
  output logic [KEY_W-1:0] o_head
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);

  logic [KEY_W-1:0] r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] r_wr;
  logic [PTR_W-1:0] r_rd;
  logic [CNT_W-1:0] r_count;
  logic             r_full;
  logic             r_empty;
  logic [KEY_W-1:0] r_head;

  logic             w_do_pop;
  logic             w_do_push;
  logic [PTR_W-1:0] w_rd_nxt;
  logic [CNT_W-1:0] w_count_nxt;

  // A push into a full FIFO is only accepted when a pop frees a slot in the same cycle.
  assign w_do_pop  = i_pop & ~r_empty;
  assign w_do_push = i_push & (~r_full | w_do_pop);
  assign w_rd_nxt  = w_do_pop ? r_rd + PTR_W'(1) : r_rd;

  always_comb begin
    w_count_nxt = r_count;
    if (w_do_push && !w_do_pop) begin
      w_count_nxt = r_count + CNT_W'(1);
    end else if (!w_do_push && w_do_pop) begin
      w_count_nxt = r_count - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr] <= i_din;
    end
  end

  // Next head bypasses the storage when the incoming token lands in the next read slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
      r_full  <= 1'b0;
      r_empty <= 1'b1;
      r_head  <= '0;
    end else begin
      if (w_do_push) begin
        r_wr <= r_wr + PTR_W'(1);
      end
      r_rd    <= w_rd_nxt;
      r_count <= w_count_nxt;
      r_full  <= (w_count_nxt == CNT_W'(FIFO_DEPTH));
      r_empty <= (w_count_nxt == '0);
      if (w_count_nxt == '0) begin
        r_head <= '0;
      end else if (w_do_push && (r_wr == w_rd_nxt)) begin
        r_head <= i_din;
      end else begin
        r_head <= r_mem[w_rd_nxt];
      end
    end
  end

  assign o_full  = r_full;
  assign o_empty = r_empty;
  assign o_head  = r_head;

endmodule

// File: rtl/key_token_encoder.sv
// Synchronises and debounces the calculator buttons, encodes each accepted press
// into a key token and buffers tokens for MB_INTERFACE over a valid/ready handshake.
module key_token_encoder
  import calc_key_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 2000,
  parameter int unsigned FIFO_DEPTH      = 4
) (
  input  logic             CLK_1MHz,
  input  logic             RSTN,
  input  logic [9:0]       BUTTON_NUM_IN,
  input  logic             BUTTON_DOT_IN,
  input  logic             BUTTON_EQUAL_IN,
  input  logic [3:0]       BUTTON_OPER_IN,
  input  logic             SHIFT_IN,
  output logic             KEY_VALID,
  output logic [KEY_W-1:0] KEY_CODE,
  input  logic             KEY_READY,
  output logic             KEY_OVF
);

  localparam int unsigned RAW_W = 17;
  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_DONE = CNT_W'(DEBOUNCE_CYCLES);

  logic [RAW_W-1:0] w_raw;
  logic [RAW_W-1:0] r_sync1;
  logic [RAW_W-1:0] r_sync2;
  logic [15:0]      w_s;
  logic             w_sh;
  logic             w_onehot;

  key_state_e       r_state;
  key_state_e       w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [CNT_W-1:0] w_cnt_inc;
  logic [15:0]      r_pat;
  logic [15:0]      w_pat_nxt;
  logic             w_push;
  logic [KEY_W-1:0] w_code;

  logic             w_full;
  logic             w_empty;
  logic             w_valid;
  logic             w_pop;
  logic             r_ovf;

  assign w_raw    = {SHIFT_IN, BUTTON_OPER_IN, BUTTON_EQUAL_IN, BUTTON_DOT_IN, BUTTON_NUM_IN};
  assign w_s      = r_sync2[15:0];
  assign w_sh     = r_sync2[16];
  assign w_onehot = (w_s != '0) && ((w_s & (w_s - 16'd1)) == '0);
  assign w_cnt_inc = (r_cnt == '1) ? r_cnt : r_cnt + CNT_W'(1);

  always_ff @(posedge CLK_1MHz or negedge RSTN) begin
    if (!RSTN) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= w_raw;
      r_sync2 <= r_sync1;
    end
  end

  always_ff @(posedge CLK_1MHz or negedge RSTN) begin
    if (!RSTN) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_pat   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_pat   <= w_pat_nxt;
    end
  end

  // Press needs the same single key for the whole count; release needs all keys up for the whole count.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_pat_nxt   = r_pat;
    w_push      = 1'b0;
    w_code      = encode_key(r_pat, w_sh);
    case (r_state)
      ST_IDLE: begin
        if (w_onehot) begin
          w_pat_nxt   = w_s;
          w_cnt_nxt   = CNT_W'(1);
          w_state_nxt = ST_PRESS;
        end
      end
      ST_PRESS: begin
        if (w_s != r_pat) begin
          w_state_nxt = ST_IDLE;
        end else if (r_cnt >= CNT_DONE) begin
          w_push      = 1'b1;
          w_state_nxt = ST_HELD;
        end else begin
          w_cnt_nxt = w_cnt_inc;
        end
      end
      ST_HELD: begin
        if (w_s == '0) begin
          w_cnt_nxt   = CNT_W'(1);
          w_state_nxt = ST_RELEASE;
        end
      end
      ST_RELEASE: begin
        if (w_s != '0) begin
          w_state_nxt = ST_HELD;
        end else if (r_cnt >= CNT_DONE) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_cnt_nxt = w_cnt_inc;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  assign w_valid = ~w_empty;
  assign w_pop   = w_valid & KEY_READY;

  key_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .KEY_W      (KEY_W)
  ) u_fifo (
    .clk     (CLK_1MHz),
    .rst_n   (RSTN),
    .i_push  (w_push),
    .i_din   (w_code),
    .i_pop   (w_pop),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_head  (KEY_CODE)
  );

  // Dropped token: full with no simultaneous pop to make room.
  always_ff @(posedge CLK_1MHz or negedge RSTN) begin
    if (!RSTN) begin
      r_ovf <= 1'b0;
    end else begin
      r_ovf <= w_push & w_full & ~w_pop;
    end
  end

  assign KEY_VALID = w_valid;
  assign KEY_OVF   = r_ovf;

endmodule

// File: tb/tb_key_token_encoder.sv
// Bench for key_token_encoder: directed scenarios plus random presses against a behavioural model.
module tb_key_token_encoder;

  localparam int unsigned D     = 4;
  localparam int unsigned DEPTH = 4;

  logic       CLK_1MHz;
  logic       RSTN;
  logic [9:0] BUTTON_NUM_IN;
  logic       BUTTON_DOT_IN;
  logic       BUTTON_EQUAL_IN;
  logic [3:0] BUTTON_OPER_IN;
  logic       SHIFT_IN;
  logic       KEY_VALID;
  logic [4:0] KEY_CODE;
  logic       KEY_READY;
  logic       KEY_OVF;

  int unsigned n_vec;
  int unsigned n_err;
  int unsigned ovf_seen;
  logic        rand_ready;

  // Reference model state
  logic [16:0] m_sync1;
  logic [16:0] m_sync2;
  int          m_mode;
  int          m_run;
  logic [15:0] m_pat;
  logic [4:0]  m_q[$];
  logic        m_ovf;

  key_token_encoder #(
    .DEBOUNCE_CYCLES (D),
    .FIFO_DEPTH      (DEPTH)
  ) dut (
    .CLK_1MHz        (CLK_1MHz),
    .RSTN            (RSTN),
    .BUTTON_NUM_IN   (BUTTON_NUM_IN),
    .BUTTON_DOT_IN   (BUTTON_DOT_IN),
    .BUTTON_EQUAL_IN (BUTTON_EQUAL_IN),
    .BUTTON_OPER_IN  (BUTTON_OPER_IN),
    .SHIFT_IN        (SHIFT_IN),
    .KEY_VALID       (KEY_VALID),
    .KEY_CODE        (KEY_CODE),
    .KEY_READY       (KEY_READY),
    .KEY_OVF         (KEY_OVF)
  );

  initial begin
    CLK_1MHz = 1'b0;
    forever #5 CLK_1MHz = ~CLK_1MHz;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Token value from the key index: digit lines run 0,9,8..1, then dot, equal, /,*,-,+.
  function automatic logic [4:0] ref_code(input logic [15:0] pat, input logic sh);
    int idx;
    idx = 0;
    for (int i = 0; i < 16; i++) if (pat[i]) idx = i;
    if (idx == 0)  return 5'd0;
    if (idx <= 9)  return 5'(10 - idx);
    if (idx <= 11) return 5'(idx);
    if (idx == 12) return 5'd15;
    if (idx == 13) return 5'd14;
    if (idx == 14) return sh ? 5'd17 : 5'd13;
    return sh ? 5'd16 : 5'd12;
  endfunction

  task automatic model_step();
    logic [15:0] s;
    logic        sh;
    logic        push;
    logic        pop;
    logic [4:0]  tok;
    if (!RSTN) begin
      m_sync1 = '0;
      m_sync2 = '0;
      m_mode  = 0;
      m_run   = 0;
      m_pat   = '0;
      m_q.delete();
      m_ovf   = 1'b0;
      return;
    end
    s    = m_sync2[15:0];
    sh   = m_sync2[16];
    push = 1'b0;
    tok  = '0;
    pop  = (m_q.size() != 0) && KEY_READY;
    case (m_mode)
      0: if ($countones(s) == 1) begin m_pat = s; m_run = 1; m_mode = 1; end
      1: begin
        if (s != m_pat) m_mode = 0;
        else if (m_run >= int'(D)) begin push = 1'b1; tok = ref_code(m_pat, sh); m_mode = 2; end
        else m_run++;
      end
      2: if (s == 0) begin m_run = 1; m_mode = 3; end
      default: begin
        if (s != 0) m_mode = 2;
        else if (m_run >= int'(D)) m_mode = 0;
        else m_run++;
      end
    endcase
    m_ovf = 1'b0;
    if (pop) void'(m_q.pop_front());
    if (push) begin
      if (m_q.size() < int'(DEPTH)) m_q.push_back(tok);
      else m_ovf = 1'b1;
    end
    m_sync2 = m_sync1;
    m_sync1 = {SHIFT_IN, BUTTON_OPER_IN, BUTTON_EQUAL_IN, BUTTON_DOT_IN, BUTTON_NUM_IN};
  endtask

  // Per-cycle comparison of all outputs against the model
  always begin
    logic       exp_valid;
    logic [4:0] exp_code;
    @(posedge CLK_1MHz);
    model_step();
    #1;
    exp_valid = (m_q.size() != 0);
    exp_code  = exp_valid ? m_q[0] : 5'd0;
    chk("valid", 32'(KEY_VALID), 32'(exp_valid));
    chk("code",  32'(KEY_CODE),  32'(exp_code));
    chk("ovf",   32'(KEY_OVF),   32'(m_ovf));
    if (KEY_OVF) ovf_seen++;
  end

  task automatic tick();
    @(negedge CLK_1MHz);
    if (rand_ready) KEY_READY = ($urandom_range(0, 2) == 0);
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic drive_pat(input logic [15:0] p);
    BUTTON_NUM_IN   = p[9:0];
    BUTTON_DOT_IN   = p[10];
    BUTTON_EQUAL_IN = p[11];
    BUTTON_OPER_IN  = p[15:12];
  endtask

  task automatic press(input logic [15:0] p);
    drive_pat(p);
    idle(8);
    drive_pat('0);
    idle(8);
  endtask

  task automatic pop_one();
    KEY_READY = 1'b1;
    tick();
    KEY_READY = 1'b0;
  endtask

  task automatic op_shift(input logic [3:0] op, input logic [4:0] exp);
    SHIFT_IN = 1'b1;
    tick();
    BUTTON_OPER_IN = op;
    idle(10);
    BUTTON_OPER_IN = '0;
    idle(8);
    SHIFT_IN = 1'b0;
    chk("s3_valid", 32'(KEY_VALID), 32'd1);
    chk("s3_code",  32'(KEY_CODE),  32'(exp));
    pop_one();
  endtask

  task automatic rand_press();
    int          k;
    logic [15:0] p;
    k = $urandom_range(0, 19);
    if (k < 16)      p = 16'(1) << k;
    else if (k < 19) p = (16'(1) << $urandom_range(0, 15)) | (16'(1) << $urandom_range(0, 15));
    else             p = '0;
    SHIFT_IN = 1'($urandom_range(0, 1));
    drive_pat(p);
    repeat ($urandom_range(1, 10)) tick();
    if ($urandom_range(0, 3) == 0) SHIFT_IN = ~SHIFT_IN;
    repeat ($urandom_range(0, 4)) tick();
    if ($urandom_range(0, 24) == 0) begin
      RSTN = 1'b0;
      tick();
      RSTN = 1'b1;
    end
    drive_pat('0);
    repeat ($urandom_range(1, 10)) tick();
  endtask

  initial begin
    logic [4:0]  got[$];
    logic [4:0]  exp5 [4];
    int unsigned ovf0;
    exp5 = '{5'd2, 5'd4, 5'd10, 5'd3};
    n_vec = 0; n_err = 0; ovf_seen = 0;
    rand_ready = 1'b0;
    RSTN = 1'b1;
    KEY_READY = 1'b0;
    SHIFT_IN = 1'b0;
    drive_pat('0);
    #1 RSTN = 1'b0;

    // Reset held while inputs toggle
    repeat (6) begin
      tick();
      drive_pat(16'($urandom));
      SHIFT_IN  = 1'($urandom);
      KEY_READY = 1'($urandom);
      chk("rst_valid", 32'(KEY_VALID), 32'd0);
      chk("rst_code",  32'(KEY_CODE),  32'd0);
      chk("rst_ovf",   32'(KEY_OVF),   32'd0);
    end
    tick();
    drive_pat('0); SHIFT_IN = 1'b0; KEY_READY = 1'b0; RSTN = 1'b1;
    idle(8);

    // Digit 2, press latency and hold until ready
    BUTTON_NUM_IN = 10'b01000_00000;
    idle(6);
    chk("s2_early", 32'(KEY_VALID), 32'd0);
    tick();
    chk("s2_rise", 32'(KEY_VALID), 32'd1);
    chk("s2_code", 32'(KEY_CODE), 32'd2);
    idle(3);
    drive_pat('0);
    idle(10);
    chk("s2_hold", 32'(KEY_VALID), 32'd1);
    chk("s2_code_hold", 32'(KEY_CODE), 32'd2);
    pop_one();
    idle(2);
    chk("s2_single", 32'(KEY_VALID), 32'd0);

    // Shifted operators
    op_shift(4'b1000, 5'd16);
    op_shift(4'b0100, 5'd17);
    op_shift(4'b0010, 5'd14);

    // Dot: short pulse, then long hold with a release glitch
    BUTTON_DOT_IN = 1'b1; idle(3); BUTTON_DOT_IN = 1'b0;
    idle(10);
    chk("s4_short", 32'(KEY_VALID), 32'd0);
    BUTTON_DOT_IN = 1'b1; idle(6);
    BUTTON_DOT_IN = 1'b0; idle(2);
    BUTTON_DOT_IN = 1'b1; idle(6);
    BUTTON_DOT_IN = 1'b0; idle(10);
    chk("s4_valid", 32'(KEY_VALID), 32'd1);
    chk("s4_code", 32'(KEY_CODE), 32'd10);
    pop_one();
    idle(2);
    chk("s4_single", 32'(KEY_VALID), 32'd0);

    // Fill past depth, then drain in order
    ovf0 = ovf_seen;
    press(16'h0100);
    press(16'h0040);
    press(16'h0400);
    press(16'h0080);
    press(16'h0800);
    chk("s5_ovf_count", ovf_seen - ovf0, 32'd1);
    KEY_READY = 1'b1;
    got.delete();
    repeat (8) begin
      if (KEY_VALID) got.push_back(KEY_CODE);
      tick();
    end
    KEY_READY = 1'b0;
    chk("s5_drain_len", 32'(got.size()), 32'd4);
    for (int i = 0; i < 4; i++)
      chk("s5_order", (i < got.size()) ? 32'(got[i]) : 32'hDEAD, 32'(exp5[i]));

    // Chord rejected, remaining key accepted; reset during press
    BUTTON_NUM_IN = 10'b00001_00001;
    idle(10);
    chk("s6_chord", 32'(KEY_VALID), 32'd0);
    BUTTON_NUM_IN = 10'b00001_00000;
    idle(10);
    drive_pat('0);
    idle(8);
    chk("s6_valid", 32'(KEY_VALID), 32'd1);
    chk("s6_code", 32'(KEY_CODE), 32'd5);
    pop_one();
    BUTTON_NUM_IN = 10'b00000_00010;
    idle(4);
    RSTN = 1'b0;
    drive_pat('0);
    idle(2);
    RSTN = 1'b1;
    idle(12);
    chk("s6_rst", 32'(KEY_VALID), 32'd0);

    // Random presses, chords, shift changes and ready traffic
    rand_ready = 1'b1;
    repeat (60) rand_press();
    rand_ready = 1'b0;
    KEY_READY = 1'b1;
    idle(20);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
